// File: rtl/hazard_pkg.sv
// Shared constants for the WISC hazard scoreboard and the decode pre-decoder.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int WB_DIST_DEF  = 3;
    localparam int LD_STALL_DEF = 1;

    typedef logic [4:0] opcode_t;

    // Opcodes the pre-decoder maps onto the register-field/early-read flags.
    localparam opcode_t OP_ST   = 5'b10000;
    localparam opcode_t OP_LD   = 5'b10001;
    localparam opcode_t OP_STU  = 5'b10011;
    localparam opcode_t OP_JR   = 5'b00101;
    localparam opcode_t OP_JAL  = 5'b00110;
    localparam opcode_t OP_JALR = 5'b00111;
    localparam opcode_t OP_LBI  = 5'b11000;
    localparam opcode_t OP_SLBI = 5'b10010;

    // Width of a countdown that must be able to hold wb_dist.
    function automatic int cnt_w(input int wb_dist);
        return (wb_dist < 1) ? 1 : $clog2(wb_dist + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One register's in-flight-write countdown plus its "producer is a load" flag.
// Latency: set/decrement take effect on the next clock edge.
// Backpressure: hold freezes the entry completely (global memory stall).
module hazard_sb_entry #(
    parameter int WB_DIST = 3,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          set,
    input  logic          set_ld,
    output logic          busy,
    output logic [CW-1:0] cnt,
    output logic          ld
);

    // Countdown toward regfile write; a new writer restarts it and owns the load flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ld  <= 1'b0;
        end else if (!hold) begin
            if (set) begin
                cnt <= CW'(WB_DIST);
                ld  <= set_ld;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    ld <= 1'b0;
                end
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside IF/ID: decode stall on pending writes, flush on redirect.
// Latency: stall/flush outputs are combinational on current state and inputs.
// Backpressure: mem_stall freezes all state; stall_decode holds PC and IF/ID.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = 8,
    parameter int AW        = $clog2(NREG),
    parameter int WB_DIST   = WB_DIST_DEF,
    parameter int LD_STALL  = LD_STALL_DEF,
    parameter int RF_BYPASS = 1,
    parameter int KILL_CYC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_vld,
    input  logic            id_rt_vld,
    input  logic            id_rs_early,
    input  logic            id_rd_early,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_dst_vld,
    input  logic            id_is_load,
    input  logic            mem_stall,
    input  logic            redirect,
    output logic            stall_decode,
    output logic            flush_fetch,
    output logic            flush_decode,
    output logic [NREG-1:0] sb_busy
);

    localparam int CW     = cnt_w(WB_DIST);
    localparam int KW     = (KILL_CYC < 1) ? 1 : $clog2(KILL_CYC + 1);
    // A load's value is forwardable to EX once its count drops to this level.
    localparam int EX_THR = WB_DIST - LD_STALL;

    logic [CW-1:0]   cnt_q [NREG];
    logic [NREG-1:0] ld_q;
    logic [KW-1:0]   kill_q;
    logic            hazard;
    logic            issue;

    // Source-operand hazards against the scoreboard, only for a real decode instruction.
    always_comb begin
        hazard = 1'b0;
        if (id_rs_vld && ld_q[id_rs] && (int'(cnt_q[id_rs]) > EX_THR)) begin
            hazard = 1'b1;
        end
        if (id_rt_vld && ld_q[id_rt] && (int'(cnt_q[id_rt]) > EX_THR)) begin
            hazard = 1'b1;
        end
        if (id_rs_early && (int'(cnt_q[id_rs]) > RF_BYPASS)) begin
            hazard = 1'b1;
        end
        if (id_rd_early && (int'(cnt_q[id_dst]) > RF_BYPASS)) begin
            hazard = 1'b1;
        end
        hazard = hazard & id_valid;
    end

    assign flush_fetch  = redirect;
    assign flush_decode = redirect | (kill_q != '0);
    // A squashed instruction never stalls: the redirect outranks it.
    assign stall_decode = hazard & ~flush_decode;
    assign issue        = id_valid & ~stall_decode & ~flush_decode & ~redirect & ~mem_stall;

    // Keep decode squashed for KILL_CYC cycles after a redirect, frozen by mem_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= '0;
        end else if (!mem_stall) begin
            if (redirect) begin
                kill_q <= KW'(KILL_CYC);
            end else if (kill_q != '0) begin
                kill_q <= kill_q - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_entry
        hazard_sb_entry #(
            .WB_DIST (WB_DIST),
            .CW      (CW)
        ) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .hold   (mem_stall),
            .set    (issue & id_dst_vld & (id_dst == AW'(g))),
            .set_ld (id_is_load),
            .busy   (sb_busy[g]),
            .cnt    (cnt_q[g]),
            .ld     (ld_q[g])
        );
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a timestamp-based reference model.
// Latency: n/a.
// Backpressure: exercises mem_stall freeze and redirect squash.
module tb_hazard_scoreboard;

    localparam int NREG = 8;
    localparam int WB   = 3;
    localparam int LDS  = 1;
    localparam int BYP  = 1;
    localparam int KILL = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_vld, id_rt_vld, id_rs_early, id_rd_early;
    logic [2:0] id_rs, id_rt, id_dst;
    logic       id_dst_vld, id_is_load, mem_stall, redirect;
    logic       stall_decode, flush_fetch, flush_decode;
    logic [7:0] sb_busy;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    // Model: live-cycle clock (advances only when the pipe moves) and the
    // cycle at which each register's newest writer holds the full count.
    int now;
    int wr_t [NREG];
    bit wr_ld [NREG];
    int rd_t;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_vld    (id_rs_vld),
        .id_rt_vld    (id_rt_vld),
        .id_rs_early  (id_rs_early),
        .id_rd_early  (id_rd_early),
        .id_dst       (id_dst),
        .id_dst_vld   (id_dst_vld),
        .id_is_load   (id_is_load),
        .mem_stall    (mem_stall),
        .redirect     (redirect),
        .stall_decode (stall_decode),
        .flush_fetch  (flush_fetch),
        .flush_decode (flush_decode),
        .sb_busy      (sb_busy)
    );

    function automatic int rem(input int r);
        int d;
        d = WB - (now - wr_t[r]);
        return (d > 0) ? d : 0;
    endfunction

    function automatic int kill_rem();
        int d;
        d = KILL - (now - rd_t);
        return (d > 0) ? d : 0;
    endfunction

    function automatic bit m_fd();
        return redirect || (kill_rem() > 0);
    endfunction

    function automatic bit m_haz();
        bit h;
        h = 1'b0;
        if (id_rs_vld && wr_ld[int'(id_rs)] && rem(int'(id_rs)) > WB - LDS) h = 1'b1;
        if (id_rt_vld && wr_ld[int'(id_rt)] && rem(int'(id_rt)) > WB - LDS) h = 1'b1;
        if (id_rs_early && rem(int'(id_rs)) > BYP) h = 1'b1;
        if (id_rd_early && rem(int'(id_dst)) > BYP) h = 1'b1;
        return id_valid && h;
    endfunction

    function automatic bit m_stall();
        return m_haz() && !m_fd();
    endfunction

    function automatic bit m_issue();
        return id_valid && !m_stall() && !m_fd() && !redirect && !mem_stall;
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (rem(r) > 0);
        return b;
    endfunction

    // Model state advance on each clock edge the pipe is not frozen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now  <= 0;
            rd_t <= -100;
            for (int r = 0; r < NREG; r++) begin
                wr_t[r]  <= -100;
                wr_ld[r] <= 1'b0;
            end
        end else if (!mem_stall) begin
            now <= now + 1;
            if (m_issue() && id_dst_vld) begin
                wr_t[int'(id_dst)]  <= now + 1;
                wr_ld[int'(id_dst)] <= id_is_load;
            end
            if (redirect) rd_t <= now + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run && rst_n === 1'b1) begin
            chk("model_stall", {31'd0, stall_decode}, {31'd0, m_stall()});
            chk("model_flush_fetch", {31'd0, flush_fetch}, {31'd0, redirect});
            chk("model_flush_decode", {31'd0, flush_decode}, {31'd0, m_fd()});
            chk("model_sb_busy", {24'd0, sb_busy}, {24'd0, m_busy()});
        end
    end

    // One decode cycle: inputs change just after the edge, checks at negedge.
    task automatic cyc(input bit v, input int rs, input bit rsv, input int rt, input bit rtv,
                       input bit rse, input bit rde, input int dst, input bit dstv,
                       input bit ld, input bit ms, input bit rd);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs       = 3'(rs);
        id_rs_vld   = rsv;
        id_rt       = 3'(rt);
        id_rt_vld   = rtv;
        id_rs_early = rse;
        id_rd_early = rde;
        id_dst      = 3'(dst);
        id_dst_vld  = dstv;
        id_is_load  = ld;
        mem_stall   = ms;
        redirect    = rd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_vld = 0; id_rt_vld = 0;
        id_rs_early = 0; id_rd_early = 0; id_dst = 0; id_dst_vld = 0;
        id_is_load = 0; mem_stall = 0; redirect = 0;
        #3;
        chk("rst_stall", {31'd0, stall_decode}, 32'd0);
        chk("rst_flush_fetch", {31'd0, flush_fetch}, 32'd0);
        chk("rst_flush_decode", {31'd0, flush_decode}, 32'd0);
        chk("rst_sb_busy", {24'd0, sb_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;

        // load-use: one bubble
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        chk("ld_issue_nostall", {31'd0, stall_decode}, 32'd0);
        cyc(1, 1, 1, 3, 1, 0, 0, 2, 1, 0, 0, 0);
        chk("lduse_stall", {31'd0, stall_decode}, 32'd1);
        cyc(1, 1, 1, 3, 1, 0, 0, 2, 1, 0, 0, 0);
        chk("lduse_release", {31'd0, stall_decode}, 32'd0);
        idle(1);
        chk("lduse_busy", {24'd0, sb_busy}, 32'h06);
        idle(3);

        // jr on ALU result: two bubbles
        cyc(1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("jr_stall1", {31'd0, stall_decode}, 32'd1);
        cyc(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("jr_stall2", {31'd0, stall_decode}, 32'd1);
        cyc(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("jr_release", {31'd0, stall_decode}, 32'd0);
        chk("jr_busy5_hi", {31'd0, sb_busy[5]}, 32'd1);
        idle(1);
        chk("jr_busy5_lo", {31'd0, sb_busy[5]}, 32'd0);
        idle(2);

        // mem_stall freezes the load's countdown
        cyc(1, 0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("ms_stall", {31'd0, stall_decode}, 32'd1);
            chk("ms_busy", {24'd0, sb_busy}, 32'h10);
        end
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ms_resume_stall", {31'd0, stall_decode}, 32'd1);
        cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ms_resume_release", {31'd0, stall_decode}, 32'd0);
        idle(3);

        // redirect squashes a stalled jalr, no scoreboard write
        cyc(1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0);
        chk("rd_pre_stall", {31'd0, stall_decode}, 32'd1);
        cyc(1, 3, 0, 0, 0, 1, 0, 7, 1, 0, 0, 1);
        chk("rd_flush_fetch", {31'd0, flush_fetch}, 32'd1);
        chk("rd_flush_decode", {31'd0, flush_decode}, 32'd1);
        chk("rd_no_stall", {31'd0, stall_decode}, 32'd0);
        cyc(1, 3, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0);
        chk("kill_flush_fetch", {31'd0, flush_fetch}, 32'd0);
        chk("kill_flush_decode", {31'd0, flush_decode}, 32'd1);
        idle(1);
        chk("kill_done", {31'd0, flush_decode}, 32'd0);
        chk("kill_no_write", {31'd0, sb_busy[7]}, 32'd0);
        idle(2);

        // back-to-back writers to r6: load flag from the newest wins
        cyc(1, 0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        chk("ow_ld_issue", {31'd0, stall_decode}, 32'd0);
        cyc(1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("ow_stall", {31'd0, stall_decode}, 32'd1);
        chk("ow_busy6", {31'd0, sb_busy[6]}, 32'd1);
        cyc(1, 6, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("ow_release", {31'd0, stall_decode}, 32'd0);
        idle(3);

        // asynchronous reset mid-operation
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_busy", {24'd0, sb_busy}, 32'h25);
        chk("pre_rst_stall", {31'd0, stall_decode}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {24'd0, sb_busy}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_decode}, 32'd0);
        chk("mid_rst_flush_fetch", {31'd0, flush_fetch}, 32'd0);
        chk("mid_rst_flush_decode", {31'd0, flush_decode}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_stall", {31'd0, stall_decode}, 32'd0);
        chk("post_rst_busy", {24'd0, sb_busy}, 32'd0);
        idle(2);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
